// File: rtl/timer_bank.sv
// timer_bank: NCH independent programmable-limit timers, each one-shot or periodic,
// with a clear/acknowledge handshake, a level done output and a one-cycle tick.
module timer_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 12
) (
  input  logic                 clk_2K,
  input  logic                 i_Rst_n,
  input  logic [NCH-1:0]       i_Enable,
  input  logic [NCH-1:0]       i_Clear,
  input  logic [NCH-1:0]       i_Periodic,
  input  logic [NCH*WIDTH-1:0] i_Limit,
  output logic [NCH*WIDTH-1:0] o_Count,
  output logic [NCH-1:0]       o_Done,
  output logic [NCH-1:0]       o_Tick,
  output logic [NCH-1:0]       o_ClrAck
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [WIDTH-1:0] limit_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nx_s;
    logic             term_s;
    logic             fired_r;
    logic             fired_nx_s;
    logic             tick_r;
    logic             tick_nx_s;
    logic             ack_r;
    logic             ack_nx_s;

    assign limit_s = i_Limit[ch*WIDTH +: WIDTH];
    // >= rather than == so a limit lowered below the current count still terminates
    assign term_s  = i_Enable[ch] && !i_Clear[ch] && (count_r >= limit_s);

    // Next-state selection: clear, periodic wrap, one-shot clamp, count, hold
    always_comb begin
      count_nx_s = count_r;
      fired_nx_s = fired_r;
      tick_nx_s  = 1'b0;
      ack_nx_s   = 1'b0;
      if (i_Clear[ch]) begin
        count_nx_s = ZERO;
        fired_nx_s = 1'b0;
        ack_nx_s   = 1'b1;
      end else if (term_s && i_Periodic[ch]) begin
        count_nx_s = ZERO;
        tick_nx_s  = 1'b1;
      end else if (term_s) begin
        count_nx_s = limit_s;
        tick_nx_s  = !fired_r;
        fired_nx_s = 1'b1;
      end else if (i_Enable[ch] && (count_r < limit_s)) begin
        count_nx_s = count_r + ONE;
      end else begin
        count_nx_s = count_r;
      end
    end

    // Channel state register with synchronous active-low reset
    always_ff @(posedge clk_2K) begin
      if (!i_Rst_n) begin
        count_r <= ZERO;
        fired_r <= 1'b0;
        tick_r  <= 1'b0;
        ack_r   <= 1'b0;
      end else begin
        count_r <= count_nx_s;
        fired_r <= fired_nx_s;
        tick_r  <= tick_nx_s;
        ack_r   <= ack_nx_s;
      end
    end

    assign o_Count[ch*WIDTH +: WIDTH] = count_r;
    assign o_Done[ch]                 = term_s && i_Rst_n;
    assign o_Tick[ch]                 = tick_r;
    assign o_ClrAck[ch]               = ack_r;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed test-plan scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_timer_bank;
  localparam int NCH = 4;
  localparam int W   = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en, clr, per;
  logic [W-1:0]   lim [NCH];
  logic [NCH*W-1:0] limit_v;
  logic [NCH*W-1:0] count_v;
  logic [NCH-1:0] done_v, tick_v, ack_v;

  int m_cnt [NCH];
  bit m_fired [NCH];
  bit m_tick [NCH];
  bit m_ack [NCH];
  int tick_cnt [NCH];
  int errors = 0;
  int checks = 0;

  timer_bank #(.NCH(NCH), .WIDTH(W)) dut (
    .clk_2K(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Clear(clr),
    .i_Periodic(per), .i_Limit(limit_v), .o_Count(count_v),
    .o_Done(done_v), .o_Tick(tick_v), .o_ClrAck(ack_v)
  );

  always #5 clk = ~clk;

  always_comb begin
    limit_v = '0;
    for (int c = 0; c < NCH; c++) limit_v[c*W +: W] = lim[c];
  end

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, ch, obs, exp);
    end
  endtask

  // Spec rules applied to plain integers at one clock edge.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int l;
      bit t;
      l = int'(lim[c]);
      t = en[c] && !clr[c] && (m_cnt[c] >= l);
      m_tick[c] = 1'b0;
      m_ack[c]  = 1'b0;
      if (!rst_n) begin
        m_cnt[c] = 0;
        m_fired[c] = 1'b0;
      end else if (clr[c]) begin
        m_cnt[c] = 0;
        m_fired[c] = 1'b0;
        m_ack[c] = 1'b1;
      end else if (t && per[c]) begin
        m_cnt[c] = 0;
        m_tick[c] = 1'b1;
      end else if (t) begin
        m_cnt[c] = l;
        m_tick[c] = !m_fired[c];
        m_fired[c] = 1'b1;
      end else if (en[c]) begin
        m_cnt[c] = m_cnt[c] + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      chk("done", c, {31'd0, done_v[c]},
          {31'd0, rst_n && en[c] && !clr[c] && (m_cnt[c] >= int'(lim[c]))});
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk("count", c, {20'd0, count_v[c*W +: W]}, m_cnt[c]);
      chk("tick", c, {31'd0, tick_v[c]}, {31'd0, m_tick[c]});
      chk("clrack", c, {31'd0, ack_v[c]}, {31'd0, m_ack[c]});
      if (tick_v[c]) tick_cnt[c]++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic zero_ticks();
    for (int c = 0; c < NCH; c++) tick_cnt[c] = 0;
  endtask

  initial begin
    rst_n = 1'b0; en = '0; clr = '0; per = '0;
    for (int c = 0; c < NCH; c++) begin
      lim[c] = 12'd0; m_cnt[c] = 0; m_fired[c] = 1'b0;
      m_tick[c] = 1'b0; m_ack[c] = 1'b0; tick_cnt[c] = 0;
    end
    run(2);
    rst_n = 1'b1;

    // Reset mid-count
    lim[0] = 12'd200; en[0] = 1'b1;
    run(100);
    chk("rst_pre_count", 0, {20'd0, count_v[11:0]}, 100);
    rst_n = 1'b0;
    run(1);
    chk("rst_count", 0, {20'd0, count_v[11:0]}, 0);
    chk("rst_done", 0, {28'd0, done_v}, 0);
    chk("rst_tick", 0, {28'd0, tick_v}, 0);
    chk("rst_ack", 0, {28'd0, ack_v}, 0);
    rst_n = 1'b1;

    // One-shot 2 s timeout
    lim[0] = 12'd3999; per[0] = 1'b0; en[0] = 1'b1;
    zero_ticks();
    run(3999);
    chk("to_count", 0, {20'd0, count_v[11:0]}, 3999);
    chk("to_done", 0, {31'd0, done_v[0]}, 1);
    chk("to_notick_yet", 0, tick_cnt[0], 0);
    run(101);
    chk("to_ticks", 0, tick_cnt[0], 1);
    chk("to_hold", 0, {20'd0, count_v[11:0]}, 3999);
    en[0] = 1'b0;

    // Periodic limit 4, then freeze
    lim[1] = 12'd4; per[1] = 1'b1; en[1] = 1'b1;
    zero_ticks();
    run(22);
    chk("per_ticks", 1, tick_cnt[1], 22 / 5);
    chk("per_count", 1, {20'd0, count_v[23:12]}, 22 % 5);
    en[1] = 1'b0;
    run(3);
    chk("per_frozen", 1, {20'd0, count_v[23:12]}, 2);
    chk("per_frozen_ticks", 1, tick_cnt[1], 4);

    // Clear handshake on ch2
    lim[2] = 12'd10; per[2] = 1'b0; en[2] = 1'b1;
    zero_ticks();
    run(7);
    chk("clr_pre", 2, {20'd0, count_v[35:24]}, 7);
    clr[2] = 1'b1;
    run(1);
    chk("clr_count", 2, {20'd0, count_v[35:24]}, 0);
    chk("clr_ack", 2, {31'd0, ack_v[2]}, 1);
    clr[2] = 1'b0;
    run(1);
    chk("clr_ack_once", 2, {31'd0, ack_v[2]}, 0);
    run(10);
    chk("clr_fire", 2, tick_cnt[2], 1);
    clr[2] = 1'b1;
    run(1);
    chk("clr_wins", 2, {31'd0, tick_v[2]}, 0);
    clr[2] = 1'b0;
    zero_ticks();
    run(11);
    chk("rearm_fire", 2, tick_cnt[2], 1);
    en[2] = 1'b0;

    // Limit lowered below count: one-shot ch1, then mode switch, periodic ch3
    clr[1] = 1'b1; clr[3] = 1'b1;
    run(1);
    clr = '0;
    lim[1] = 12'd60; per[1] = 1'b0; en[1] = 1'b1;
    run(50);
    lim[1] = 12'd20;
    zero_ticks();
    run(1);
    chk("low_os_count", 1, {20'd0, count_v[23:12]}, 20);
    chk("low_os_tick", 1, tick_cnt[1], 1);
    per[1] = 1'b1;
    run(1);
    chk("switch_count", 1, {20'd0, count_v[23:12]}, 0);
    chk("switch_tick", 1, tick_cnt[1], 2);
    en[1] = 1'b0;
    lim[3] = 12'd60; per[3] = 1'b1; en[3] = 1'b1;
    run(50);
    lim[3] = 12'd20;
    zero_ticks();
    run(1);
    chk("low_per_count", 3, {20'd0, count_v[47:36]}, 0);
    chk("low_per_tick", 3, tick_cnt[3], 1);

    // Independence and edge limits
    clr = '1;
    run(1);
    clr = '0;
    lim[0] = 12'd0; lim[1] = 12'd1; lim[2] = 12'd4095; lim[3] = 12'd10;
    per = 4'b1001; en = 4'b1111;
    zero_ticks();
    run(4100);
    chk("ind_ticks", 0, tick_cnt[0], 4100);
    chk("ind_ticks", 1, tick_cnt[1], 1);
    chk("ind_ticks", 2, tick_cnt[2], 1);
    chk("ind_ticks", 3, tick_cnt[3], 4100 / 11);
    chk("ind_sat", 2, {20'd0, count_v[35:24]}, 4095);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(63) != 0);
      en = 4'($urandom);
      for (int c = 0; c < NCH; c++) begin
        clr[c] = ($urandom_range(7) == 0);
        if ($urandom_range(15) == 0) per[c] = ~per[c];
        if ($urandom_range(15) == 0) lim[c] = 12'($urandom_range(15));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Bank of NCH independent programmable-limit timers on the 2 kHz game clock.
- Each channel supports two modes:
  - one-shot: counts to a limit and holds.
  - periodic: counts to a limit, wraps to 0 and repeats.
- Each channel has a clear/acknowledge handshake to the global FSM, a level "done" output and a one-cycle "tick" pulse.
- Replaces single fixed-width saturating counters: dealer delays, display blink timing and the 2 s timeout can each run on their own channel.

Parameters:
- NCH, 4, number of timer channels (1..16).
- WIDTH, 12, counter width per channel in bits (2..24).

Ports:
- clk_2K  in  1  2 kHz system clock; all state updates on its rising edge.
- i_Rst_n  in  1  Synchronous reset, active-low, sampled on rising edge of clk_2K.
- i_Enable  in  NCH  Per-channel count enable (bit ch = channel ch).
- i_Clear  in  NCH  Per-channel clear request.
- i_Periodic  in  NCH  Per-channel mode: 0 = one-shot, 1 = periodic.
- i_Limit  in  NCH*WIDTH  Per-channel terminal value; channel ch occupies bits [ch*WIDTH +: WIDTH].
- o_Count  out  NCH*WIDTH  Per-channel current count, same packing as i_Limit.
- o_Done  out  NCH  Combinational level: terminal condition present this cycle.
- o_Tick  out  NCH  Registered one-cycle pulse per terminal event.
- o_ClrAck  out  NCH  Registered one-cycle acknowledge of a sampled clear.

Behaviour:
- Reset (i_Rst_n == 0 at the edge): all counts, o_Tick, o_ClrAck and the internal fired flags go to 0.
- Reset has priority over every other input.
- o_Done is 0 while i_Rst_n == 0.
- Per-channel terminal condition T[ch] = i_Enable[ch] && !i_Clear[ch] && (count[ch] >= limit[ch]).
  - The >= comparison covers a limit lowered below the current count.
- o_Done[ch] = T[ch] && i_Rst_n (combinational, no latency).
- Per-channel priority at each edge, highest first:
  1. Clear: i_Clear[ch] = 1 -> count <= 0, fired <= 0, o_ClrAck[ch] <= 1. The mode and enable inputs are ignored.
  2. Terminal, periodic: T[ch] && i_Periodic[ch] -> count <= 0, o_Tick[ch] <= 1.
  3. Terminal, one-shot: T[ch] && !i_Periodic[ch] -> count <= limit[ch] (clamp, then hold). If fired == 0: o_Tick[ch] <= 1 and fired <= 1. If fired == 1: o_Tick[ch] <= 0.
  4. Count: i_Enable[ch] && count < limit -> count <= count + 1.
  5. Idle: otherwise count holds.
- o_Tick and o_ClrAck are 0 on any edge where their set condition does not hold, so they are never high for more than one cycle per event.
- Acknowledge latency: o_ClrAck high in the cycle after the edge that sampled i_Clear.
  - If i_Clear is held for k cycles, o_ClrAck is high for k cycles, delayed by 1.
- Periodic period = limit + 1 enabled cycles.
  - limit = 0 in periodic mode: o_Tick high every enabled cycle after the first.
  - limit = 0 in one-shot mode: o_Done high immediately while enabled; a single o_Tick follows.
- One-shot re-arm: fired clears only on i_Clear or reset.
  - Changing mode or limit does not re-arm.
  - Deasserting enable freezes the count and fired.
- Switching a one-shot channel to periodic while it sits at its limit: it wraps to 0 on the next enabled edge and ticks.
- Count arithmetic is WIDTH-bit unsigned.
  - The increment never exceeds the limit, so no wrap-around past 2^WIDTH-1 occurs.
  - limit = 2^WIDTH-1 is legal.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.

Test Plan:
- Reset mid-count: ch0 enabled, count = 100, i_Rst_n low one edge -> o_Count[ch0] = 0, o_Tick = 0, o_ClrAck = 0 the next cycle. o_Done = 0 during reset.
- One-shot 2 s timeout: WIDTH = 12, limit = 3999, enable held.
  - After 3999 edges, count = 3999 and o_Done = 1.
  - o_Tick = 1 for exactly one cycle.
  - Count holds at 3999 for 100 further cycles with no further tick.
- Periodic mode, limit = 4: count sequence 0,1,2,3,4,0,1…
  - o_Tick pulses every 5 enabled cycles.
  - Deassert enable for 3 cycles -> count frozen, no tick.
- Clear handshake: clear ch2 at count = 7 for 1 cycle -> count = 0 and o_ClrAck[2] = 1 for exactly one cycle, one cycle later.
  - Clear asserted together with a terminal condition -> clear wins, no tick.
  - After clear, the one-shot fires again at the limit.
- Limit lowered below count: one-shot ch1 at count = 50, limit changed to 20.
  - Next edge: count = 20 and one tick.
  - Same stimulus on a periodic channel: count = 0 and one tick.
- Independence and edge limits: all 4 channels at different limits (0, 1, 4095, 10) in mixed modes, run concurrently.
  - Each channel's tick count and period match its own limit and mode with no cross-channel interference.
  - limit = 4095 saturates without wrap.
